// File: rtl/core_pkg.sv
// Shared definitions for the partial-sum reduction block.
// Holds the default parameter values, the controller state encoding and
// the width-derivation helpers used by psum_reduce and psum_add_tree.
package core_pkg;

    localparam int COL_DEF     = 8;
    localparam int BW_PSUM_DEF = 12;
    localparam int CNT_BW_DEF  = 4;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_ACCUM = 2'd1;
    localparam logic [1:0] ENC_DRAIN = 2'd2;
    localparam logic [1:0] ENC_OUT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_ACCUM = ENC_ACCUM,
        ST_DRAIN = ENC_DRAIN,
        ST_OUT   = ENC_OUT
    } state_t;

    // One row sum: one extra bit so |most negative lane| is representable,
    // plus clog2(col) bits of growth across the lanes.
    function automatic int tree_width(input int c, input int b);
        return b + $clog2(c) + 1;
    endfunction

    // Group total: a row sum grown by up to 2^cnt_bw rows.
    function automatic int sw_width(input int c, input int b, input int n);
        return b + $clog2(c) + n + 1;
    endfunction

endpackage

// File: rtl/psum_add_tree.sv
// Combinational lane reduction for one psum row.
// Ports:
//   abs_mode - 1: sum absolute lane values, 0: sum signed lane values
//   row      - col lanes of bw_psum-bit two's-complement values
//   lane_sum - signed sum of all lanes, wide enough that it never overflows
module psum_add_tree
    import core_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int bw_psum = BW_PSUM_DEF
) (
    input  logic                                       abs_mode,
    input  logic [col*bw_psum-1:0]                     row,
    output logic signed [tree_width(col, bw_psum)-1:0] lane_sum
);

    localparam int TW = tree_width(col, bw_psum);

    logic signed [bw_psum-1:0] lane_s;
    logic signed [TW-1:0]      ext_s;
    logic signed [TW-1:0]      mag_s;
    logic signed [TW-1:0]      acc_s;

    // Sign-extend (or take magnitude of) every lane and add them up; the
    // extra bit makes -(-2^(bw_psum-1)) come out as a clean positive value.
    always_comb begin
        acc_s  = {TW{1'b0}};
        lane_s = {bw_psum{1'b0}};
        ext_s  = {TW{1'b0}};
        mag_s  = {TW{1'b0}};
        for (int k = 0; k < col; k++) begin
            lane_s = signed'(row[k*bw_psum +: bw_psum]);
            ext_s  = TW'(lane_s);
            if (abs_mode && lane_s[bw_psum-1]) begin
                mag_s = -ext_s;
            end else begin
                mag_s = ext_s;
            end
            acc_s = acc_s + mag_s;
        end
    end

    assign lane_sum = acc_s;

endmodule

// File: rtl/psum_reduce.sv
// Group reducer: sums every lane of grp_len+1 psum rows into one signed total.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   start, grp_len,
//   abs_mode             - group request, accepted only when idle
//   in, in_valid,
//   in_ready             - row stream, accepted only while accumulating
//   sum_out, out_valid,
//   out_ready            - result handshake; sum_out holds after it
//   busy                 - high whenever a group is in flight
// Each accepted row is reduced into tree_r, then folded into acc_r on the
// following cycle; the DRAIN state covers that final fold.
module psum_reduce
    import core_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int bw_psum = BW_PSUM_DEF,
    parameter int cnt_bw  = CNT_BW_DEF
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [cnt_bw-1:0]                          grp_len,
    input  logic                                       abs_mode,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [col*bw_psum-1:0]                     in,
    output logic [sw_width(col, bw_psum, cnt_bw)-1:0]  sum_out,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       busy
);

    localparam int SW = sw_width(col, bw_psum, cnt_bw);
    localparam int TW = tree_width(col, bw_psum);

    state_t                state_r;
    logic signed [SW-1:0]  acc_r;
    logic signed [TW-1:0]  tree_r;
    logic                  pend_r;
    logic [cnt_bw-1:0]     cnt_r;
    logic [cnt_bw-1:0]     grp_len_r;
    logic                  abs_r;
    logic signed [SW-1:0]  sum_out_r;
    logic                  out_valid_r;
    logic                  in_ready_r;
    logic                  busy_r;
    logic signed [TW-1:0]  tree_sum_s;

    psum_add_tree #(
        .col     (col),
        .bw_psum (bw_psum)
    ) u_tree (
        .abs_mode (abs_r),
        .row      (in),
        .lane_sum (tree_sum_s)
    );

    // Controller, row pipeline, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            acc_r       <= {SW{1'b0}};
            tree_r      <= {TW{1'b0}};
            pend_r      <= 1'b0;
            cnt_r       <= {cnt_bw{1'b0}};
            grp_len_r   <= {cnt_bw{1'b0}};
            abs_r       <= 1'b0;
            sum_out_r   <= {SW{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            // Fold the previous cycle's row sum; a start below overrides this.
            if (pend_r) begin
                acc_r <= acc_r + SW'(tree_r);
            end
            pend_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        grp_len_r  <= grp_len;
                        abs_r      <= abs_mode;
                        acc_r      <= {SW{1'b0}};
                        cnt_r      <= {cnt_bw{1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        tree_r <= tree_sum_s;
                        pend_r <= 1'b1;
                        cnt_r  <= cnt_r + cnt_bw'(1);
                        // Compare before the increment so a full-size group
                        // ends on its last row even though cnt_r wraps.
                        if (cnt_r == grp_len_r) begin
                            in_ready_r <= 1'b0;
                            state_r    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last row sum is folded this same edge.
                    sum_out_r   <= acc_r + SW'(tree_r);
                    out_valid_r <= 1'b1;
                    state_r     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sum_out   = sum_out_r;
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_psum_reduce.sv
// Self-checking bench for psum_reduce at default parameters.
module tb_psum_reduce;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [3:0]         grp_len;
    logic               abs_mode;
    logic               in_valid;
    logic               in_ready;
    logic [95:0]        in;
    logic signed [19:0] sum_out;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int lanes [16][8];

    typedef struct {
        string name;
        int    glen;
        bit    absm;
        int    lane_val;
        int    mode;
        int    hold;
        int    exp;
    } vec_t;

    psum_reduce dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .grp_len   (grp_len),
        .abs_mode  (abs_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .sum_out   (sum_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] pack_row(input int r);
        logic [95:0] v;
        logic [31:0] w;
        v = 96'd0;
        for (int k = 0; k < 8; k++) begin
            w = lanes[r][k];
            v[k*12 +: 12] = w[11:0];
        end
        return v;
    endfunction

    // Reference: plain integer sum of the group's lanes.
    function automatic int model_sum(input int glen, input bit absm);
        int s;
        s = 0;
        for (int r = 0; r <= glen; r++) begin
            for (int k = 0; k < 8; k++) begin
                if (absm && lanes[r][k] < 0) s = s - lanes[r][k];
                else                         s = s + lanes[r][k];
            end
        end
        return s;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_sum"}, int'(sum_out), 0);
        chk({tag, "_ovalid"}, int'(out_valid), 0);
        chk({tag, "_iready"}, int'(in_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // mode: 0 in_valid always high, 1 toggling, 2 random.
    task automatic run_group(input string tag, input int glen, input bit absm,
                             input int mode, input int hold, input int exp);
        int r;
        int guard;
        bit v;
        bit acc;
        start = 1'b1; grp_len = glen[3:0]; abs_mode = absm;
        step();
        start = 1'b0;
        chk({tag, "_busy_on"}, int'(busy), 1);
        chk({tag, "_iready_on"}, int'(in_ready), 1);
        r = 0; guard = 0;
        while (r <= glen && guard < 200) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            in_valid = v;
            in = v ? pack_row(r) : 96'($urandom());
            acc = v && in_ready;
            step();
            if (acc) r++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 200) chk({tag, "_rows_timeout"}, r, glen + 1);
        chk({tag, "_drain_ovalid"}, int'(out_valid), 0);
        chk({tag, "_drain_iready"}, int'(in_ready), 0);
        step();
        chk({tag, "_ovalid"}, int'(out_valid), 1);
        chk({tag, "_sum"}, int'(sum_out), exp);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0; start = 1'b1; in_valid = 1'b1;
            in = 96'($urandom());
            step();
            chk({tag, "_hold_ovalid"}, int'(out_valid), 1);
            chk({tag, "_hold_sum"}, int'(sum_out), exp);
            chk({tag, "_hold_iready"}, int'(in_ready), 0);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_done_ovalid"}, int'(out_valid), 0);
        chk({tag, "_done_busy"}, int'(busy), 0);
        chk({tag, "_kept_sum"}, int'(sum_out), exp);
    endtask

    task automatic fill_const(input int val);
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 8; k++) lanes[r][k] = val;
    endtask

    initial begin
        vec_t vecs [7];
        int   glen;
        bit   absm;
        vecs[0] = '{"one_row_ones",  0, 1'b0,     1, 0, 0,       8};
        vecs[1] = '{"four_row_twos", 3, 1'b0,     2, 1, 0,      64};
        vecs[2] = '{"neg_one",       0, 1'b0,    -1, 0, 0,      -8};
        vecs[3] = '{"neg_one_abs",   0, 1'b1,    -1, 0, 0,       8};
        vecs[4] = '{"min_full",     15, 1'b0, -2048, 0, 0, -262144};
        vecs[5] = '{"min_full_abs", 15, 1'b1, -2048, 0, 0,  262144};
        vecs[6] = '{"hold_out",      1, 1'b0,     5, 0, 5,      80};

        reset = 1'b1; start = 1'b0; grp_len = 4'd0; abs_mode = 1'b0;
        in_valid = 1'b0; in = 96'd0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        check_zero("reset");

        // Rows offered while idle must have no effect.
        fill_const(7);
        in_valid = 1'b1; in = pack_row(0);
        step(); step();
        in_valid = 1'b0;
        chk("idle_iready", int'(in_ready), 0);

        for (int i = 0; i < 7; i++) begin
            fill_const(vecs[i].lane_val);
            run_group(vecs[i].name, vecs[i].glen, vecs[i].absm,
                      vecs[i].mode, vecs[i].hold, vecs[i].exp);
        end

        // Reset after two of four rows, then a fresh single-row group.
        fill_const(9);
        start = 1'b1; grp_len = 4'd3; abs_mode = 1'b0;
        step();
        start = 1'b0; in_valid = 1'b1; in = pack_row(0);
        step(); step();
        in_valid = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check_zero("mid_reset");
        fill_const(3);
        run_group("after_reset", 0, 1'b0, 0, 1, 24);

        // Reset while holding a result in OUT.
        fill_const(4);
        start = 1'b1; grp_len = 4'd0;
        step();
        start = 1'b0; in_valid = 1'b1; in = pack_row(0);
        step();
        in_valid = 1'b0;
        step();
        chk("out_reset_pre", int'(out_valid), 1);
        reset = 1'b1; out_ready = 1'b0; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        check_zero("out_reset");

        // Random groups against the integer model.
        for (int t = 0; t < 12; t++) begin
            glen = $urandom_range(0, 15);
            absm = 1'($urandom_range(0, 1));
            for (int r = 0; r < 16; r++)
                for (int k = 0; k < 8; k++)
                    lanes[r][k] = int'($urandom_range(0, 4095)) - 2048;
            if (t == 0) lanes[0][0] = -2048;
            run_group($sformatf("rand%0d", t), glen, absm, 2,
                      $urandom_range(0, 3), model_sum(glen, absm));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
